wb_stim_slave: RTL
==================

WB_STIM_SLAVE -- requirements
Module: wb_stim_slave

Interface
REQ-001 Parameter DEPTH, default 8, instruction FIFO entries; power of two, 2..64.
REQ-002 Parameter NOP_WORD, default 32'hE1A00000, word returned on fetch from an empty FIFO.
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 i_inst_valid  in  1  stimulus word offered.
REQ-006 o_inst_ready  out  1  FIFO can accept a word.
REQ-007 i_inst  in  32  instruction word from sequence driver.
REQ-008 i_wb_adr  in  32  core bus address.
REQ-009 i_wb_sel  in  16  core byte selects.
REQ-010 i_wb_we  in  1  core write enable.
REQ-011 i_wb_dat  in  128  core write data.
REQ-012 i_wb_cyc, i_wb_stb  in  1 each  core cycle / strobe.
REQ-013 o_wb_dat  out  128  read data to core.
REQ-014 o_wb_ack, o_wb_err  out  1 each  transfer acknowledge / error.
REQ-015 o_res_valid  out  1  captured core write available.
REQ-016 i_res_ready  in  1  result monitor accepts capture.
REQ-017 o_res_data, o_res_adr  out  32 each  captured write word and its address.
REQ-018 o_fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-019 o_underrun  out  1  sticky: fetch served from empty FIFO.
REQ-020 o_fetch_cnt  out  16  completed read transfers, wraps 16'hFFFF -> 0.

Function
REQ-021 o_inst_ready = (o_fifo_count != DEPTH); push on i_inst_valid & o_inst_ready.
REQ-022 Push and pop in same cycle leave count unchanged; push-when-full never occurs since ready is low.
REQ-023 FSM states IDLE, ACK, WAIT_RES; sole state register, encoding free.
REQ-024 IDLE, request = i_wb_cyc & i_wb_stb; no request -> stay IDLE.
REQ-025 IDLE, request with i_wb_sel == 0 -> ACK with o_wb_err (not o_wb_ack) pulsed; no pop, no capture.
REQ-026 IDLE, read request -> pop FIFO head (or NOP_WORD if empty, set o_underrun), register word replicated into all four 32-bit lanes of o_wb_dat, go ACK.
REQ-027 IDLE, write request with result slot empty -> capture lane i_wb_adr[3:2] of i_wb_dat and i_wb_adr into o_res_data/o_res_adr, set o_res_valid, go ACK.
REQ-028 IDLE, write request with result slot full -> WAIT_RES, no ack.
REQ-029 WAIT_RES: slot freed (i_res_ready & o_res_valid) -> capture same cycle slot frees, go ACK; i_wb_cyc low -> IDLE, no capture, no ack.
REQ-030 ACK: o_wb_ack (or o_wb_err) high exactly one cycle, unconditionally return IDLE; next request evaluated in IDLE.
REQ-031 Latency: ack asserted in cycle after request sampled in IDLE (one wait state); back-to-back transfers every 2 cycles minimum.
REQ-032 o_res_valid cleared on i_res_ready & o_res_valid unless refilled same cycle; data held stable while valid & !ready.
REQ-033 o_fetch_cnt increments in ACK for successful reads only.
REQ-034 o_wb_dat holds last read data outside ACK; o_wb_ack/o_wb_err low outside ACK.

Reset
REQ-035 rst high at rising edge: FSM IDLE, FIFO emptied (count 0), o_wb_ack 0, o_wb_err 0, o_wb_dat 0, o_res_valid 0, o_res_data 0, o_res_adr 0, o_underrun 0, o_fetch_cnt 0.
REQ-036 Reset mid-transfer (ACK or WAIT_RES) aborts: no ack issued after reset cycle, pending capture discarded.
REQ-037 o_inst_ready low during reset cycle; high first cycle after.

Verification
REQ-038 Push 32'hE0821003, then read at adr 0 -> ack in 2nd cycle, o_wb_dat = {4{32'hE0821003}}, count 1->0, o_fetch_cnt 1.
REQ-039 Push DEPTH words with i_inst_valid held -> o_inst_ready low at count 8; 9th word not accepted; 8 reads return words in order.
REQ-040 Read with empty FIFO -> o_wb_dat = {4{32'hE1A00000}}, o_underrun 1, stays 1 until rst.
REQ-041 Write adr 32'h104, lane 1 = 32'hDEADBEEF, i_res_ready 0, then second write -> first captured (res_adr 32'h104), second stalls in WAIT_RES; raise i_res_ready -> second acked, data captured.
REQ-042 i_wb_sel = 0 request -> o_wb_err one cycle, o_wb_ack 0, FIFO count unchanged.
REQ-043 rst asserted in WAIT_RES -> next cycle IDLE, o_res_valid 0, no ack; o_fetch_cnt 16'hFFFF plus one read -> 0.

Source files
------------

// File: rtl/wb_stim_slave.sv
// Wishbone stimulus slave: serves instruction fetches from a push FIFO and
// captures core writes into a single-entry result slot for a monitor.
module wb_stim_slave #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_inst_valid,
    output logic                       o_inst_ready,
    input  logic [31:0]                i_inst,
    input  logic [31:0]                i_wb_adr,
    input  logic [15:0]                i_wb_sel,
    input  logic                       i_wb_we,
    input  logic [127:0]               i_wb_dat,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    output logic [127:0]               o_wb_dat,
    output logic                       o_wb_ack,
    output logic                       o_wb_err,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [31:0]                o_res_data,
    output logic [31:0]                o_res_adr,
    output logic [$clog2(DEPTH):0]     o_fifo_count,
    output logic                       o_underrun,
    output logic [15:0]                o_fetch_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_RES = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [127:0]       dat_q, dat_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [31:0]        res_adr_q, res_adr_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        fetch_cnt_q, fetch_cnt_d;
    logic               rd_xfer_q, rd_xfer_d;
    logic [31:0]        mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               req;
    logic               res_free;
    logic [31:0]        lane_word;

    // Ready is forced low while reset is held so nothing is pushed into a FIFO being cleared.
    assign o_inst_ready = ~rst & (count_q != FULL_CNT);
    assign push         = i_inst_valid & o_inst_ready;
    assign req          = i_wb_cyc & i_wb_stb;
    assign res_free     = i_res_ready & res_valid_q;

    // Select the 32-bit write lane addressed by adr[3:2].
    always_comb begin
        lane_word = i_wb_dat[31:0];
        case (i_wb_adr[3:2])
            2'd0: lane_word = i_wb_dat[31:0];
            2'd1: lane_word = i_wb_dat[63:32];
            2'd2: lane_word = i_wb_dat[95:64];
            2'd3: lane_word = i_wb_dat[127:96];
            default: lane_word = i_wb_dat[31:0];
        endcase
    end

    // Bus FSM, result slot and FIFO pointer next-state logic.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        dat_d       = dat_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_adr_d   = res_adr_q;
        underrun_d  = underrun_q;
        fetch_cnt_d = fetch_cnt_q;
        rd_xfer_d   = rd_xfer_q;
        pop         = 1'b0;

        // Monitor drains the slot; a capture below may refill it in the same cycle.
        if (res_free) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (i_wb_sel == 16'h0000) begin
                        err_d     = 1'b1;
                        rd_xfer_d = 1'b0;
                        state_d   = S_ACK;
                    end else if (!i_wb_we) begin
                        rd_xfer_d = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = S_ACK;
                        if (count_q != '0) begin
                            pop   = 1'b1;
                            dat_d = {4{mem_q[rd_ptr_q]}};
                        end else begin
                            dat_d      = {4{NOP_WORD}};
                            underrun_d = 1'b1;
                        end
                    end else if (!res_valid_q) begin
                        rd_xfer_d   = 1'b0;
                        res_valid_d = 1'b1;
                        res_data_d  = lane_word;
                        res_adr_d   = i_wb_adr;
                        ack_d       = 1'b1;
                        state_d     = S_ACK;
                    end else begin
                        rd_xfer_d = 1'b0;
                        state_d   = S_WAIT_RES;
                    end
                end
            end
            S_WAIT_RES: begin
                // An abandoned cycle wins over a slot that happens to free now.
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (res_free) begin
                    res_valid_d = 1'b1;
                    res_data_d  = lane_word;
                    res_adr_d   = i_wb_adr;
                    ack_d       = 1'b1;
                    state_d     = S_ACK;
                end
            end
            S_ACK: begin
                if (rd_xfer_q) begin
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                end
                rd_xfer_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_adr_q   <= '0;
            underrun_q  <= 1'b0;
            fetch_cnt_q <= '0;
            rd_xfer_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_adr_q   <= res_adr_d;
            underrun_q  <= underrun_d;
            fetch_cnt_q <= fetch_cnt_d;
            rd_xfer_q   <= rd_xfer_d;
        end
    end

    // FIFO storage; contents are don't-care until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_inst;
        end
    end

    assign o_wb_dat     = dat_q;
    assign o_wb_ack     = ack_q;
    assign o_wb_err     = err_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_adr    = res_adr_q;
    assign o_fifo_count = count_q;
    assign o_underrun   = underrun_q;
    assign o_fetch_cnt  = fetch_cnt_q;

endmodule
